divider_24bit_seq: RTL and testbench

- Iterative restoring divider; inverse of the 24-bit mantissa multiplier.
- Divides a 2N-bit dividend (a product-width value) by an N-bit divisor, giving an N-bit quotient and an N-bit remainder.
- Sits in the FPU division path: mantissa division for FP divide, with the exponent handled elsewhere.
- Valid/ready on both sides; one quotient bit per clock.

---
 rtl/divider_pkg.sv | 11 +
 rtl/divider_step.sv | 25 ++
 rtl/divider_24bit_seq.sv | 139 +++++++++++++
 tb/tb_divider_24bit_seq.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/divider_pkg.sv
// rtl/divider_pkg.sv - shared width, state and operand types for the mantissa divider
package divider_pkg;

  localparam int DIV_N = 24;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} div_state_t;

  typedef logic [DIV_N-1:0]   mant_t;
  typedef logic [2*DIV_N-1:0] prod_t;

endpackage

// File: rtl/divider_step.sv
// rtl/divider_step.sv - one combinational restoring-division step
module divider_step
  import divider_pkg::*;
#(
  parameter int N = DIV_N
) (
  input  logic [N-1:0] p,
  input  logic         s_msb,
  input  logic [N-1:0] divisor,
  output logic [N-1:0] p_next,
  output logic         q_bit
);

  // T carries one extra bit so the compare sees the full shifted value;
  // since P < divisor on entry, the difference always fits back in N bits.
  logic [N:0] t;

  // shift in the next dividend bit, compare, and conditionally subtract
  always_comb begin
    t      = {p, s_msb};
    q_bit  = (t >= {1'b0, divisor});
    p_next = q_bit ? (t[N-1:0] - divisor) : t[N-1:0];
  end

endmodule

// File: rtl/divider_24bit_seq.sv
// rtl/divider_24bit_seq.sv - iterative restoring divider, 2N-bit by N-bit, one quotient bit per clock
module divider_24bit_seq
  import divider_pkg::*;
#(
  parameter int N = DIV_N
) (
  input  logic           clk,
  input  logic           rstn,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [2*N-1:0] dividend,
  input  logic [N-1:0]   divisor,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [N-1:0]   quotient,
  output logic [N-1:0]   remainder,
  output logic           div_by_zero,
  output logic           overflow
);

  localparam int            CW   = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  div_state_t    state;
  div_state_t    state_next;

  logic [N-1:0]  p_q;
  logic [N-1:0]  s_q;
  logic [N-1:0]  divisor_q;
  logic [CW-1:0] cnt_q;

  logic [N-1:0]  p_next;
  logic          q_bit;
  logic [N-1:0]  s_next;
  logic          last_step;
  logic          is_zero;
  logic          is_ovf;
  logic          err_hold;

  divider_step #(.N(N)) u_step (
    .p       (p_q),
    .s_msb   (s_q[N-1]),
    .divisor (divisor_q),
    .p_next  (p_next),
    .q_bit   (q_bit)
  );

  // accept-time error detection and per-step helpers
  always_comb begin
    is_zero   = (divisor == '0);
    is_ovf    = !is_zero && (dividend[2*N-1:N] >= divisor);
    s_next    = {s_q[N-2:0], q_bit};
    last_step = (cnt_q == LAST);
    // an error result spends a single cycle in BUSY so it is presented one
    // clock after accept, matching the registered shape of the normal path
    err_hold  = div_by_zero || overflow;
  end

  // state register
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // next-state and handshake outputs
  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          state_next = BUSY;
        end
      end
      BUSY: begin
        if (err_hold || last_step) begin
          state_next = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // operand capture, iteration registers and result registers
  always_ff @(posedge clk) begin
    if (!rstn) begin
      p_q         <= '0;
      s_q         <= '0;
      divisor_q   <= '0;
      cnt_q       <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            div_by_zero <= is_zero;
            overflow    <= is_ovf;
            cnt_q       <= '0;
            divisor_q   <= divisor;
            if (is_zero || is_ovf) begin
              quotient  <= '1;
              remainder <= '0;
            end else begin
              p_q <= dividend[2*N-1:N];
              s_q <= dividend[N-1:0];
            end
          end
        end
        BUSY: begin
          if (!err_hold) begin
            p_q   <= p_next;
            s_q   <= s_next;
            cnt_q <= cnt_q + 1'b1;
            if (last_step) begin
              quotient  <= s_next;
              remainder <= p_next;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_divider_24bit_seq.sv
// tb/tb_divider_24bit_seq.sv - randomized self-checking bench for divider_24bit_seq
module tb_divider_24bit_seq;
  import divider_pkg::*;

  localparam int N = 24;

  logic        clk;
  logic        rstn;
  logic        in_valid;
  logic        in_ready;
  prod_t       dividend;
  mant_t       divisor;
  logic        out_valid;
  logic        out_ready;
  mant_t       quotient;
  mant_t       remainder;
  logic        div_by_zero;
  logic        overflow;

  int n_checks;
  int n_pass;

  divider_24bit_seq #(.N(N)) dut (
    .clk         (clk),
    .rstn        (rstn),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .dividend    (dividend),
    .divisor     (divisor),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero),
    .overflow    (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end else begin
      n_pass++;
    end
  endtask

  // reference: plain integer division on the full-width operands
  task automatic model(input prod_t dd, input mant_t dv,
                       output mant_t q, output mant_t r,
                       output logic dz, output logic ov, output int lat);
    prod_t quo;
    prod_t rem;
    q = '0; r = '0; dz = 1'b0; ov = 1'b0;
    if (dv == 0) begin
      dz = 1'b1; q = '1; r = '0; lat = 1;
    end else begin
      quo = dd / {24'd0, dv};
      rem = dd % {24'd0, dv};
      if (quo > 48'hFF_FFFF) begin
        ov = 1'b1; q = '1; r = '0; lat = 1;
      end else begin
        q = quo[N-1:0]; r = rem[N-1:0]; lat = N;
      end
    end
  endtask

  task automatic run_op(input prod_t dd, input mant_t dv, input string tag,
                        input int hold, input bit busy_noise);
    mant_t eq, er;
    logic  edz, eov;
    int    elat;
    int    lat;
    model(dd, dv, eq, er, edz, eov, elat);
    @(negedge clk);
    check({tag, "_in_ready"}, in_ready, 1);
    in_valid = 1'b1;
    dividend = dd;
    divisor  = dv;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    lat = 0;
    while (out_valid !== 1'b1 && lat < 60) begin
      if (busy_noise && lat < 5) begin
        in_valid = 1'b1;
        dividend = {$urandom, $urandom} & 48'hFFFF_FFFF_FFFF;
        divisor  = mant_t'($urandom);
      end else begin
        in_valid = 1'b0;
      end
      @(posedge clk);
      #1;
      lat++;
    end
    in_valid = 1'b0;
    check({tag, "_latency"}, lat, elat);
    check({tag, "_quotient"}, quotient, eq);
    check({tag, "_remainder"}, remainder, er);
    check({tag, "_div_by_zero"}, div_by_zero, edz);
    check({tag, "_overflow"}, overflow, eov);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      check({tag, "_hold_valid"}, out_valid, 1);
      check({tag, "_hold_in_ready"}, in_ready, 0);
      check({tag, "_hold_quotient"}, quotient, eq);
      check({tag, "_hold_remainder"}, remainder, er);
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check({tag, "_post_valid"}, out_valid, 0);
    check({tag, "_post_in_ready"}, in_ready, 1);
    check({tag, "_post_quotient"}, quotient, eq);
  endtask

  initial begin
    prod_t dd;
    mant_t dv;
    int    mode;
    n_checks  = 0;
    n_pass    = 0;
    rstn      = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    dividend  = '0;
    divisor   = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_quotient", quotient, 0);
    check("rst_remainder", remainder, 0);
    check("rst_div_by_zero", div_by_zero, 0);
    check("rst_overflow", overflow, 0);
    rstn = 1'b1;

    run_op(48'd640000000, 24'd8000, "exact", 0, 1'b0);
    run_op(48'd640000007, 24'd8000, "rem", 0, 1'b0);
    run_op(48'd1234, 24'd0, "dbz", 0, 1'b0);
    run_op(48'd5 << 24, 24'd5, "ovf", 0, 1'b0);
    run_op((48'd5 << 24) - 48'd1, 24'd5, "ovf_edge", 0, 1'b0);
    run_op(48'd987654321, 24'd12345, "bp_noise", 10, 1'b1);

    // reset during step 12 of 24
    @(negedge clk);
    in_valid = 1'b1;
    dividend = 48'd640000000;
    divisor  = 24'd8000;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (11) @(posedge clk);
    #1;
    rstn = 1'b0;
    @(posedge clk);
    #1;
    rstn = 1'b1;
    check("midrst_in_ready", in_ready, 1);
    check("midrst_out_valid", out_valid, 0);
    check("midrst_quotient", quotient, 0);
    check("midrst_remainder", remainder, 0);
    check("midrst_flags", {div_by_zero, overflow}, 0);
    repeat (30) begin
      @(posedge clk);
      #1;
      check("midrst_no_result", out_valid, 0);
    end
    run_op(48'd100, 24'd7, "after_rst", 0, 1'b0);

    for (int k = 0; k < 40; k++) begin
      mode = $urandom_range(0, 9);
      dv = mant_t'($urandom) >> $urandom_range(0, 23);
      if (dv == 0) dv = 24'd1;
      if (mode == 0) begin
        dv = '0;
        dd = {$urandom, $urandom} & 48'hFFFF_FFFF_FFFF;
      end else if (mode == 1) begin
        dd = {24'hFF_FFFF, mant_t'($urandom)};
      end else begin
        dd = {mant_t'($urandom % dv), mant_t'($urandom)};
      end
      run_op(dd, dv, $sformatf("rand%0d", k), (k % 7 == 0) ? 3 : 0, k[0]);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
